dbg_dump_reader: RTL

- Bus initiator that drives the core data-memory/MMIO interface (`address`, `write_data`, `write_enable`, `read_data`) to read a block of consecutive words.
- Results are streamed out on a valid/ready port, e.g. toward a UART or JTAG bridge.
- Main use: snapshot the debug window, x0..x31 at 0x2000_0000..0x2000_007C plus PC at 0x2000_0080, or dump RAM regions.
- It is read-only and shares the bus with the CPU through a request/grant pair.

---
 rtl/dbg_dump_reader.sv | 127 ++++++++++++
 1 files changed

// File: rtl/dbg_dump_reader.sv
// Debug/RAM dump reader: borrows the core data bus through a request/grant pair,
// reads a block of consecutive words and streams them out on a valid/ready port.
module dbg_dump_reader #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [31:0]      base_addr,
  input  logic [CNT_W-1:0] word_count,
  output logic             busy,
  output logic             done,
  output logic             bus_req,
  input  logic             bus_gnt,
  output logic [31:0]      address,
  output logic [31:0]      write_data,
  output logic [3:0]       write_enable,
  input  logic [31:0]      read_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_data,
  output logic [31:0]      out_addr
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_ADDR,
    S_CAPT,
    S_OUT,
    S_FIN
  } state_t;

  state_t           state_q, state_d;
  logic [31:0]      cur_addr_q, cur_addr_d;
  logic [CNT_W-1:0] remaining_q, remaining_d;
  logic [31:0]      address_q, address_d;
  logic [31:0]      out_data_q, out_data_d;
  logic [31:0]      out_addr_q, out_addr_d;

  // Word alignment discards the two low address bits.
  logic unused_base_bits;
  assign unused_base_bits = ^base_addr[1:0];

  always_comb begin
    state_d     = state_q;
    cur_addr_d  = cur_addr_q;
    remaining_d = remaining_q;
    out_data_d  = out_data_q;
    out_addr_d  = out_addr_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          cur_addr_d  = {base_addr[31:2], 2'b00};
          remaining_d = word_count;
          state_d     = (word_count == '0) ? S_FIN : S_REQ;
        end
      end
      S_REQ: begin
        if (bus_gnt) state_d = S_ADDR;
      end
      S_ADDR: begin
        state_d = bus_gnt ? S_CAPT : S_REQ;
      end
      S_CAPT: begin
        // Address has been stable for two cycles, so both registered RAM data
        // and combinational MMIO data are valid here.
        if (bus_gnt) begin
          out_data_d = read_data;
          out_addr_d = cur_addr_q;
          state_d    = S_OUT;
        end else begin
          state_d = S_REQ;
        end
      end
      S_OUT: begin
        if (out_ready) begin
          remaining_d = remaining_q - CNT_W'(1);
          cur_addr_d  = cur_addr_q + 32'd4;
          if (remaining_d == '0) state_d = S_FIN;
          else if (bus_gnt)      state_d = S_ADDR;
          else                   state_d = S_REQ;
        end
      end
      S_FIN: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // The bus address is loaded on entry to ADDR and held everywhere else.
    address_d = (state_d == S_ADDR) ? cur_addr_d : address_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      cur_addr_q  <= '0;
      remaining_q <= '0;
      address_q   <= '0;
      out_data_q  <= '0;
      out_addr_q  <= '0;
    end else begin
      state_q     <= state_d;
      cur_addr_q  <= cur_addr_d;
      remaining_q <= remaining_d;
      address_q   <= address_d;
      out_data_q  <= out_data_d;
      out_addr_q  <= out_addr_d;
    end
  end

  assign busy         = (state_q != S_IDLE);
  assign done         = (state_q == S_FIN);
  assign bus_req      = (state_q == S_REQ) || (state_q == S_ADDR) ||
                        (state_q == S_CAPT) || (state_q == S_OUT);
  assign out_valid    = (state_q == S_OUT);
  assign address      = address_q;
  assign write_data   = '0;
  assign write_enable = '0;
  assign out_data     = out_data_q;
  assign out_addr     = out_addr_q;

endmodule
